// File: rtl/i2c_pkg.sv
// Constants and state encoding shared by the I2C target and fmc_i2c_controller.
package i2c_pkg;

  localparam logic [6:0] CLPD_ADDR = 7'b0111110;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE       = 4'd0;
  localparam state_t ST_ADDR       = 4'd1;
  localparam state_t ST_ADDR_ACK   = 4'd2;
  localparam state_t ST_PTR        = 4'd3;
  localparam state_t ST_PTR_ACK    = 4'd4;
  localparam state_t ST_WDATA      = 4'd5;
  localparam state_t ST_WDATA_ACK  = 4'd6;
  localparam state_t ST_RDATA      = 4'd7;
  localparam state_t ST_RDATA_MACK = 4'd8;
  localparam state_t ST_IGNORE     = 4'd9;

endpackage

// File: rtl/ff_filter.sv
// Glitch filter: output follows the input only after STAGES identical samples.
module ff_filter #(
  parameter int STAGES = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] taps;

  // Shift in samples; change the output only on a unanimous history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      taps <= {STAGES{1'b1}};
      q    <= 1'b1;
    end else begin
      taps <= {taps[STAGES-2:0], d};
      if (&taps) begin
        q <= 1'b1;
      end else if (~|taps) begin
        q <= 1'b0;
      end else begin
        q <= q;
      end
    end
  end

endmodule

// File: rtl/i2c_target_responder.sv
// I2C target with a 2-bit register pointer and four 8-bit registers; no clock stretching.
module i2c_target_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR   = CLPD_ADDR,
  parameter int         FILTER_STAGES = 7,
  parameter logic [7:0] REG0_INIT     = 8'h00
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       SCL_I,
  input  logic       SDA_I,
  output logic       SDA_T,
  output logic [7:0] REG0_Q,
  output logic       WR_STROBE,
  output logic [1:0] WR_ADDR,
  output logic [7:0] WR_DATA,
  output logic       BUSY
);

  logic [1:0] scl_sync, sda_sync;
  logic       scl_f, sda_f, scl_d, sda_d;
  logic       scl_rise, scl_fall, start, stop;
  state_t     state;
  logic [3:0] bit_cnt;
  logic [7:0] shreg, rx_byte, data_at_ptr, data_at_inc;
  logic [1:0] ptr, ptr_inc;
  logic       rw, ack_drv, mack;
  logic [7:0] regs [4];

  // Pin synchronizers and previous-value registers for edge detection.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], SCL_I};
      sda_sync <= {sda_sync[0], SDA_I};
      scl_d    <= scl_f;
      sda_d    <= sda_f;
    end
  end

  ff_filter #(.STAGES(FILTER_STAGES)) u_scl_filter (
    .clk(CLK), .rst_n(RST_N), .d(scl_sync[1]), .q(scl_f)
  );

  ff_filter #(.STAGES(FILTER_STAGES)) u_sda_filter (
    .clk(CLK), .rst_n(RST_N), .d(sda_sync[1]), .q(sda_f)
  );

  assign scl_rise    = scl_f & ~scl_d;
  assign scl_fall    = ~scl_f & scl_d;
  assign start       = scl_f & scl_d & sda_d & ~sda_f;
  assign stop        = scl_f & scl_d & ~sda_d & sda_f;
  assign rx_byte     = {shreg[6:0], sda_f};
  assign ptr_inc     = ptr + 2'd1;
  assign data_at_ptr = regs[ptr];
  assign data_at_inc = regs[ptr_inc];

  // Protocol FSM; START/STOP take priority over every state.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      bit_cnt   <= 4'd0;
      shreg     <= 8'h00;
      ptr       <= 2'd0;
      rw        <= 1'b0;
      ack_drv   <= 1'b0;
      mack      <= NACK;
      regs[0]   <= REG0_INIT;
      regs[1]   <= 8'h00;
      regs[2]   <= 8'h00;
      regs[3]   <= 8'h00;
      REG0_Q    <= REG0_INIT;
      SDA_T     <= 1'b1;
      WR_STROBE <= 1'b0;
      WR_ADDR   <= 2'd0;
      WR_DATA   <= 8'h00;
      BUSY      <= 1'b0;
    end else begin
      WR_STROBE <= 1'b0;
      REG0_Q    <= regs[0];
      if (start) begin
        state   <= ST_ADDR;
        bit_cnt <= 4'd0;
        ack_drv <= 1'b0;
        SDA_T   <= 1'b1;
      end else if (stop) begin
        state   <= ST_IDLE;
        bit_cnt <= 4'd0;
        ack_drv <= 1'b0;
        SDA_T   <= 1'b1;
        BUSY    <= 1'b0;
      end else begin
        case (state)
          ST_ADDR, ST_PTR, ST_WDATA: begin
            if (scl_rise) begin
              shreg <= rx_byte;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= 4'd0;
                ack_drv <= 1'b0;
                if (state == ST_ADDR) begin
                  if (rx_byte[7:1] == TARGET_ADDR) begin
                    state <= ST_ADDR_ACK;
                    rw    <= rx_byte[0];
                    BUSY  <= 1'b1;
                  end else begin
                    state <= ST_IGNORE;
                  end
                end else if (state == ST_PTR) begin
                  ptr   <= rx_byte[1:0];
                  state <= ST_PTR_ACK;
                end else begin
                  regs[ptr] <= rx_byte;
                  WR_STROBE <= 1'b1;
                  WR_ADDR   <= ptr;
                  WR_DATA   <= rx_byte;
                  ptr       <= ptr_inc;
                  state     <= ST_WDATA_ACK;
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          // First falling edge starts the ACK, the second ends it.
          ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
            if (scl_fall) begin
              if (!ack_drv) begin
                SDA_T   <= ACK;
                ack_drv <= 1'b1;
              end else begin
                ack_drv <= 1'b0;
                bit_cnt <= 4'd0;
                if (state == ST_ADDR_ACK && rw) begin
                  SDA_T <= data_at_ptr[7];
                  shreg <= {data_at_ptr[6:0], 1'b1};
                  state <= ST_RDATA;
                end else begin
                  SDA_T <= 1'b1;
                  state <= (state == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
                end
              end
            end
          end
          ST_RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                SDA_T   <= 1'b1;
                bit_cnt <= 4'd0;
                state   <= ST_RDATA_MACK;
              end else begin
                SDA_T <= shreg[7];
                shreg <= {shreg[6:0], 1'b1};
              end
            end
          end
          ST_RDATA_MACK: begin
            if (scl_rise) begin
              mack <= sda_f;
            end else if (scl_fall) begin
              if (mack == ACK) begin
                ptr     <= ptr_inc;
                SDA_T   <= data_at_inc[7];
                shreg   <= {data_at_inc[6:0], 1'b1};
                bit_cnt <= 4'd0;
                state   <= ST_RDATA;
              end else begin
                SDA_T <= 1'b1;
                state <= ST_IGNORE;
              end
            end
          end
          ST_IDLE, ST_IGNORE: begin
            SDA_T <= 1'b1;
          end
          default: begin
            SDA_T <= 1'b1;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_responder.sv
// Directed bench: bit-level I2C master model at 100 kHz with write/read scoreboards.
`timescale 1ns/1ps
module tb_i2c_target_responder;

  localparam int TQ = 2500;

  typedef struct packed {
    logic [1:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_t;
  logic [7:0] reg0_q;
  logic       wr_strobe;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  int  checks = 0;
  int  errors = 0;
  int  strobe_cnt = 0;
  wr_t exp_q[$];
  logic [7:0] rd_q[$];

  assign sda_bus = sda_m & sda_t;

  always #25 clk = ~clk;

  i2c_target_responder dut (
    .CLK(clk), .RST_N(rst_n), .SCL_I(scl_m), .SDA_I(sda_bus), .SDA_T(sda_t),
    .REG0_Q(reg0_q), .WR_STROBE(wr_strobe), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
    .BUSY(busy)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bit_cycle(input logic b, input logic glitch, output logic s);
    sda_m = b;
    if (glitch) begin
      #(TQ/2); scl_m = 1'b1; #50; scl_m = 1'b0; #(TQ/2 - 50);
    end else begin
      #(TQ);
    end
    scl_m = 1'b1; #(TQ);
    s = sda_bus;  #(TQ);
    scl_m = 1'b0; #(TQ);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #(TQ);
    scl_m = 1'b1; #(TQ);
    sda_m = 1'b0; #(TQ);
    scl_m = 1'b0; #(TQ);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #(TQ);
    scl_m = 1'b1; #(TQ);
    sda_m = 1'b1; #(TQ);
  endtask

  task automatic write_byte(input logic [7:0] b, input int gbit, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], (i == gbit), s);
    bit_cycle(1'b1, 1'b0, ack);
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, 1'b0, s);
      d[i] = s;
    end
    bit_cycle(ack_bit, 1'b0, s);
  endtask

  // Write-strobe scoreboard: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (wr_strobe) begin
      wr_t e;
      strobe_cnt++;
      chk("strobe_expected", 8'(exp_q.size() > 0), 8'h01);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", 8'(wr_addr), 8'(e.addr));
        chk("wr_data", wr_data, e.data);
      end
    end
  end

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       ack;
    logic       s;
    logic [7:0] d;

    repeat (5) @(negedge clk);
    chk("rst_sda_t", 8'(sda_t), 8'h01);
    chk("rst_busy", 8'(busy), 8'h00);
    chk("rst_reg0", reg0_q, 8'h00);
    chk("rst_strobe", 8'(wr_strobe), 8'h00);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Single write to register 0
    i2c_start();
    write_byte(8'h7C, -1, ack); chk("t31_addr_ack", 8'(ack), 8'h00);
    chk("t31_busy", 8'(busy), 8'h01);
    write_byte(8'h00, -1, ack); chk("t31_ptr_ack", 8'(ack), 8'h00);
    exp_q.push_back('{addr: 2'd0, data: 8'hA5});
    write_byte(8'hA5, -1, ack); chk("t31_data_ack", 8'(ack), 8'h00);
    i2c_stop();
    chk("t31_busy_after_stop", 8'(busy), 8'h00);
    chk("t31_reg0", reg0_q, 8'hA5);

    // Burst write with pointer wrap 3 -> 0
    i2c_start();
    write_byte(8'h7C, -1, ack); chk("t32_addr_ack", 8'(ack), 8'h00);
    write_byte(8'h01, -1, ack); chk("t32_ptr_ack", 8'(ack), 8'h00);
    exp_q.push_back('{addr: 2'd1, data: 8'h11});
    write_byte(8'h11, -1, ack); chk("t32_d1_ack", 8'(ack), 8'h00);
    exp_q.push_back('{addr: 2'd2, data: 8'h22});
    write_byte(8'h22, -1, ack); chk("t32_d2_ack", 8'(ack), 8'h00);
    exp_q.push_back('{addr: 2'd3, data: 8'h33});
    write_byte(8'h33, -1, ack); chk("t32_d3_ack", 8'(ack), 8'h00);
    exp_q.push_back('{addr: 2'd0, data: 8'h44});
    write_byte(8'h44, -1, ack); chk("t32_d4_ack", 8'(ack), 8'h00);
    i2c_stop();
    chk("t32_reg0", reg0_q, 8'h44);

    // Pointer set, repeated START, two-byte read
    i2c_start();
    write_byte(8'h7C, -1, ack); chk("t33_waddr_ack", 8'(ack), 8'h00);
    write_byte(8'h02, -1, ack); chk("t33_ptr_ack", 8'(ack), 8'h00);
    i2c_start();
    write_byte(8'h7D, -1, ack); chk("t33_raddr_ack", 8'(ack), 8'h00);
    rd_q.push_back(8'h22);
    rd_q.push_back(8'h33);
    read_byte(1'b0, d); chk("t33_rd0", d, rd_q.pop_front());
    read_byte(1'b1, d); chk("t33_rd1", d, rd_q.pop_front());
    chk("t33_release", 8'(sda_t), 8'h01);
    i2c_stop();

    // Foreign address: no ACK, no strobe, not busy
    i2c_start();
    write_byte(8'hA0, -1, ack); chk("t34_addr_nack", 8'(ack), 8'h01);
    chk("t34_busy", 8'(busy), 8'h00);
    write_byte(8'h00, -1, ack); chk("t34_data_nack", 8'(ack), 8'h01);
    i2c_stop();
    chk("t34_busy_after", 8'(busy), 8'h00);

    // 50 ns SCL spike in the middle of a data byte
    i2c_start();
    write_byte(8'h7C, -1, ack); chk("t35_addr_ack", 8'(ack), 8'h00);
    write_byte(8'h03, -1, ack); chk("t35_ptr_ack", 8'(ack), 8'h00);
    exp_q.push_back('{addr: 2'd3, data: 8'h5A});
    write_byte(8'h5A, 4, ack); chk("t35_data_ack", 8'(ack), 8'h00);
    i2c_stop();

    // Reset asserted while the target drives its address ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) begin
      d = 8'h7C;
      bit_cycle(d[i], 1'b0, s);
    end
    chk("t36_ack_driven", 8'(sda_t), 8'h00);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    chk("t36_sda_released", 8'(sda_t), 8'h01);
    repeat (3) @(negedge clk);
    chk("t36_busy_reset", 8'(busy), 8'h00);
    chk("t36_reg0_reset", reg0_q, 8'h00);
    rst_n = 1'b1;
    bit_cycle(1'b1, 1'b0, s);
    i2c_stop();
    i2c_start();
    write_byte(8'h7C, -1, ack); chk("t36_addr_ack", 8'(ack), 8'h00);
    write_byte(8'h00, -1, ack); chk("t36_ptr_ack", 8'(ack), 8'h00);
    exp_q.push_back('{addr: 2'd0, data: 8'h3C});
    write_byte(8'h3C, -1, ack); chk("t36_data_ack", 8'(ack), 8'h00);
    i2c_stop();
    chk("t36_reg0", reg0_q, 8'h3C);

    repeat (10) @(negedge clk);
    chk("pending_writes", 8'(exp_q.size()), 8'h00);
    chk("strobe_total", 8'(strobe_cnt), 8'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
